// File: rtl/ecp_pkg.sv
// ECP core shared definitions: instruction fields, ALU/condition codes,
// register indices and controller states.
package ecp_pkg;

    typedef enum logic [1:0] {
        MODE_IMM  = 2'b00,
        MODE_ALU  = 2'b01,
        MODE_COPY = 2'b10,
        MODE_COND = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        OP_OR   = 3'd0,
        OP_NAND = 3'd1,
        OP_NOR  = 3'd2,
        OP_AND  = 3'd3,
        OP_ADD  = 3'd4,
        OP_SUB  = 3'd5,
        OP_XOR  = 3'd6,
        OP_SHL1 = 3'd7
    } alu_op_e;

    typedef enum logic [2:0] {
        CC_NEVER  = 3'd0,
        CC_EQ     = 3'd1,
        CC_LT     = 3'd2,
        CC_LE     = 3'd3,
        CC_ALWAYS = 3'd4,
        CC_NE     = 3'd5,
        CC_GE     = 3'd6,
        CC_GT     = 3'd7
    } cond_e;

    localparam logic [2:0] REG_IO   = 3'd6;
    localparam logic [2:0] REG_RSVD = 3'd7;
    localparam int         NUM_REGS = 6;

    typedef enum logic [2:0] {
        S_FETCH,
        S_EXEC,
        S_IN_WAIT,
        S_OUT_WAIT,
        S_HALT
    } state_e;

    // zero/neg describe R3 interpreted as a signed value
    function automatic logic cond_taken(
        input cond_e cc,
        input logic  zero,
        input logic  neg
    );
        logic t;
        t = 1'b0;
        unique case (cc)
            CC_NEVER:  t = 1'b0;
            CC_EQ:     t = zero;
            CC_LT:     t = neg;
            CC_LE:     t = neg | zero;
            CC_ALWAYS: t = 1'b1;
            CC_NE:     t = ~zero;
            CC_GE:     t = ~neg;
            CC_GT:     t = ~neg & ~zero;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/ecp_alu.sv
// ECP combinational ALU: eight logic/arithmetic ops at DATA_W bits,
// wrapping arithmetic, no flags.
module ecp_alu
    import ecp_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  alu_op_e           op,
    output logic [DATA_W-1:0] y
);

    always_comb begin
        y = '0;
        unique case (op)
            OP_OR:   y = a | b;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_AND:  y = a & b;
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_XOR:  y = a ^ b;
            OP_SHL1: y = {a[DATA_W-2:0], 1'b0};
        endcase
    end

endmodule

// File: rtl/ecp_core_param.sv
// ECP core top: fetch/execute controller, six-entry register file, pc
// and valid/ready I/O registers around an external synchronous program store.
module ecp_core_param
    import ecp_pkg::*;
#(
    parameter int          DATA_W   = 8,
    parameter int          PC_W     = 8,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [7:0]        imem_data,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              halted
);

    localparam logic [PC_W-1:0] PC_RST = PC_W'(RESET_PC);
    localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [7:0]        ir_q, ir;
    logic [DATA_W-1:0] regs [NUM_REGS];

    mode_e             mode;
    logic [2:0]        src, dst;
    logic [DATA_W-1:0] src_val, alu_y;
    logic              is_halt, is_in, is_out;
    logic              in_fire, out_fire;
    logic              r3_zero, r3_neg;

    logic              wr_en;
    logic [2:0]        wr_idx;
    logic [DATA_W-1:0] wr_data;

    // imem_data is only valid in EXEC; stalled states replay the latched copy
    assign ir   = (state_q == S_EXEC) ? imem_data : ir_q;
    assign mode = mode_e'(ir[7:6]);
    assign src  = ir[5:3];
    assign dst  = ir[2:0];

    assign is_halt = (mode == MODE_COPY) && (src == REG_RSVD)
                     && (dst == REG_RSVD);
    assign is_in   = (mode == MODE_COPY) && (src == REG_IO);
    assign is_out  = (mode == MODE_COPY) && (src != REG_IO)
                     && (dst == REG_IO);

    assign in_fire  = (state_q == S_IN_WAIT) && in_valid && in_ready;
    assign out_fire = (state_q == S_OUT_WAIT) && out_valid && out_ready;

    assign r3_zero = (regs[3] == '0);
    assign r3_neg  = regs[3][DATA_W-1];

    assign imem_addr = pc_q;
    assign halted    = (state_q == S_HALT);

    always_comb begin
        src_val = '0;
        if (src < 3'(NUM_REGS)) src_val = regs[src];
    end

    ecp_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .a  (regs[1]),
        .b  (regs[2]),
        .op (alu_op_e'(ir[2:0])),
        .y  (alu_y)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_FETCH;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        wr_en   = 1'b0;
        wr_idx  = dst;
        wr_data = src_val;
        unique case (state_q)
            S_FETCH: state_d = S_EXEC;
            S_EXEC: begin
                state_d = S_FETCH;
                pc_d    = pc_q + PC_ONE;
                unique case (mode)
                    MODE_IMM: begin
                        wr_en   = 1'b1;
                        wr_idx  = 3'd0;
                        wr_data = DATA_W'(ir[5:0]);
                    end
                    MODE_ALU: begin
                        wr_en   = 1'b1;
                        wr_idx  = 3'd3;
                        wr_data = alu_y;
                    end
                    MODE_COPY: begin
                        if (is_halt) begin
                            state_d = S_HALT;
                            pc_d    = pc_q;
                        end else if (is_in) begin
                            state_d = S_IN_WAIT;
                            pc_d    = pc_q;
                        end else if (is_out) begin
                            state_d = S_OUT_WAIT;
                            pc_d    = pc_q;
                        end else begin
                            wr_en = 1'b1;
                        end
                    end
                    MODE_COND: begin
                        if (cond_taken(cond_e'(ir[2:0]), r3_zero, r3_neg))
                            pc_d = PC_W'(regs[0]);
                    end
                endcase
            end
            S_IN_WAIT: begin
                if (in_fire) begin
                    wr_data = in_data;
                    if (dst == REG_IO) begin
                        state_d = S_OUT_WAIT;
                    end else begin
                        state_d = S_FETCH;
                        pc_d    = pc_q + PC_ONE;
                        wr_en   = 1'b1;
                    end
                end
            end
            S_OUT_WAIT: begin
                if (out_fire) begin
                    state_d = S_FETCH;
                    pc_d    = pc_q + PC_ONE;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q      <= PC_RST;
            ir_q      <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            pc_q <= pc_d;
            if (state_q == S_EXEC) ir_q <= imem_data;
            // index 6 and 7 have no storage, so those writes vanish
            if (wr_en && (wr_idx < 3'(NUM_REGS))) regs[wr_idx] <= wr_data;
            if ((state_q == S_EXEC) && is_in) in_ready <= 1'b1;
            if (in_fire) in_ready <= 1'b0;
            if ((state_q == S_EXEC) && is_out) begin
                out_valid <= 1'b1;
                out_data  <= src_val;
            end
            if (in_fire && (dst == REG_IO)) begin
                out_valid <= 1'b1;
                out_data  <= in_data;
            end
            if (out_fire) out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ecp_core_param.sv
// Bench for ecp_core_param: an 8/8 and a 16/4 instance share a program ROM,
// an input queue and an output scoreboard.
module tb_ecp_core_param;
    import ecp_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a = 1'b0;
    logic        rst_b = 1'b0;
    logic        sel = 1'b0;
    logic [7:0]  rom [256];
    logic [7:0]  addr_a, imem_a, imem_b;
    logic [3:0]  addr_b;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] in_data = 16'h0;
    logic        in_ready_a, out_valid_a, halted_a;
    logic        in_ready_b, out_valid_b, halted_b;
    logic [7:0]  out_data_a;
    logic [15:0] out_data_b;

    ecp_core_param #(
        .DATA_W(8), .PC_W(8), .RESET_PC(0)
    ) u_a (
        .clk       (clk),
        .rst       (rst_a),
        .imem_addr (addr_a),
        .imem_data (imem_a),
        .in_valid  (in_valid),
        .in_data   (in_data[7:0]),
        .in_ready  (in_ready_a),
        .out_valid (out_valid_a),
        .out_data  (out_data_a),
        .out_ready (out_ready),
        .halted    (halted_a)
    );

    ecp_core_param #(
        .DATA_W(16), .PC_W(4), .RESET_PC(0)
    ) u_b (
        .clk       (clk),
        .rst       (rst_b),
        .imem_addr (addr_b),
        .imem_data (imem_b),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready_b),
        .out_valid (out_valid_b),
        .out_data  (out_data_b),
        .out_ready (out_ready),
        .halted    (halted_b)
    );

    always @(posedge clk) begin
        imem_a <= rom[addr_a];
        imem_b <= rom[{4'h0, addr_b}];
    end

    logic        obs_in_ready, obs_out_valid, obs_halted;
    logic [15:0] obs_out_data;
    logic [7:0]  obs_addr;

    always_comb begin
        if (sel) begin
            obs_in_ready  = in_ready_b;
            obs_out_valid = out_valid_b;
            obs_halted    = halted_b;
            obs_out_data  = out_data_b;
            obs_addr      = {4'h0, addr_b};
        end else begin
            obs_in_ready  = in_ready_a;
            obs_out_valid = out_valid_a;
            obs_halted    = halted_a;
            obs_out_data  = {8'h0, out_data_a};
            obs_addr      = addr_a;
        end
    end

    typedef struct {
        logic        s;
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] y;
    } alu_vec_t;

    typedef struct {
        logic        s;
        logic [15:0] r3;
        logic [2:0]  cc;
        logic        taken;
    } cond_vec_t;

    alu_vec_t    alu_tab [15];
    cond_vec_t   cond_tab [15];
    logic [15:0] in_q [$];
    logic [15:0] exp_q [$];

    int    n_chk = 0;
    int    n_fail = 0;
    int    in_delay, out_delay;
    int    in_rdy_cyc, out_vld_cyc, unstable, first_out;
    int    in_addr_bad, overlap = 0;
    string tag = "";

    function automatic logic [7:0] f_imm(input logic [5:0] v);
        return {2'b00, v};
    endfunction
    function automatic logic [7:0] f_alu(input logic [2:0] op);
        return {2'b01, 3'b000, op};
    endfunction
    function automatic logic [7:0] f_cp(input logic [2:0] s,
                                        input logic [2:0] d);
        return {2'b10, s, d};
    endfunction
    function automatic logic [7:0] f_cnd(input logic [2:0] cc);
        return {2'b11, 3'b000, cc};
    endfunction
    localparam logic [7:0] HALT = 8'hBF;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = HALT;
    endtask

    task automatic start(input logic s);
        sel = s;
        rst_a = 1'b0;
        rst_b = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_data = 16'h0;
        in_q.delete();
        exp_q.delete();
        in_delay = 0;
        out_delay = 0;
        repeat (2) step();
        check({tag, " reset_state"},
              {obs_addr, obs_in_ready, obs_out_valid,
               obs_out_data, obs_halted}, 32'h0);
        if (s) rst_b = 1'b1;
        else   rst_a = 1'b1;
    endtask

    task automatic run(input int budget);
        int          cyc = 0;
        int          iw = 0;
        int          ow = 0;
        logic        prev_ov = 1'b0;
        logic        prev_ir = 1'b0;
        logic [15:0] held = 16'h0;
        logic [7:0]  ir_addr = 8'h0;
        in_rdy_cyc = 0;
        out_vld_cyc = 0;
        unstable = 0;
        first_out = -1;
        in_addr_bad = 0;
        while (!obs_halted && cyc < budget) begin
            if (obs_in_ready && obs_out_valid) overlap++;
            if (obs_in_ready) begin
                in_rdy_cyc++;
                if (!prev_ir) ir_addr = obs_addr;
                else if (obs_addr !== ir_addr) in_addr_bad++;
            end
            prev_ir = obs_in_ready;
            if (obs_out_valid) begin
                out_vld_cyc++;
                if (first_out < 0) first_out = cyc;
                if (prev_ov && obs_out_data !== held) unstable++;
                held = obs_out_data;
            end
            prev_ov = obs_out_valid;
            in_valid = obs_in_ready && (iw >= in_delay)
                       && (in_q.size() > 0);
            in_data = (in_q.size() > 0) ? in_q[0] : 16'h0;
            out_ready = obs_out_valid && (ow >= out_delay);
            if (in_valid) begin
                void'(in_q.pop_front());
                iw = 0;
            end else if (obs_in_ready) begin
                iw++;
            end
            if (out_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL %s unexpected_out: got %0h, none due",
                             tag, obs_out_data);
                end else begin
                    check({tag, " out_data"}, obs_out_data,
                          exp_q.pop_front());
                end
                ow = 0;
            end else if (obs_out_valid) begin
                ow++;
            end
            step();
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        check({tag, " halted"}, obs_halted, 1);
        check({tag, " outputs_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        alu_tab = '{
            '{1'b0, 3'd0, 16'h00C5, 16'h005C, 16'h00DD},
            '{1'b0, 3'd1, 16'h00C5, 16'h005C, 16'h00BB},
            '{1'b0, 3'd2, 16'h00C5, 16'h005C, 16'h0022},
            '{1'b0, 3'd3, 16'h00C5, 16'h005C, 16'h0044},
            '{1'b0, 3'd4, 16'h00C5, 16'h005C, 16'h0021},
            '{1'b0, 3'd5, 16'h00C5, 16'h005C, 16'h0069},
            '{1'b0, 3'd6, 16'h00C5, 16'h005C, 16'h0099},
            '{1'b0, 3'd7, 16'h00C5, 16'h005C, 16'h008A},
            '{1'b0, 3'd4, 16'h00FF, 16'h0001, 16'h0000},
            '{1'b0, 3'd5, 16'h0000, 16'h0001, 16'h00FF},
            '{1'b1, 3'd4, 16'hFFFF, 16'h0001, 16'h0000},
            '{1'b1, 3'd5, 16'h0000, 16'h0001, 16'hFFFF},
            '{1'b1, 3'd7, 16'h8001, 16'h0003, 16'h0002},
            '{1'b1, 3'd4, 16'h00FF, 16'h0001, 16'h0100},
            '{1'b1, 3'd6, 16'h1234, 16'h00FF, 16'h12CB}
        };
        cond_tab = '{
            '{1'b0, 16'h0080, 3'd2, 1'b1},
            '{1'b0, 16'h0080, 3'd6, 1'b0},
            '{1'b0, 16'h0000, 3'd1, 1'b1},
            '{1'b0, 16'h0000, 3'd5, 1'b0},
            '{1'b0, 16'h0000, 3'd3, 1'b1},
            '{1'b0, 16'h0001, 3'd7, 1'b1},
            '{1'b0, 16'h0001, 3'd3, 1'b0},
            '{1'b0, 16'h007F, 3'd2, 1'b0},
            '{1'b0, 16'h0055, 3'd0, 1'b0},
            '{1'b0, 16'h0055, 3'd4, 1'b1},
            '{1'b0, 16'h00FF, 3'd6, 1'b0},
            '{1'b0, 16'h0000, 3'd7, 1'b0},
            '{1'b1, 16'h0080, 3'd2, 1'b0},
            '{1'b1, 16'h8000, 3'd3, 1'b1},
            '{1'b1, 16'h8000, 3'd7, 1'b0}
        };

        tag = "t1";
        clear_rom();
        rom[0] = f_imm(6'd5);
        rom[1] = f_cp(3'd0, 3'd1);
        rom[2] = f_imm(6'd3);
        rom[3] = f_cp(3'd0, 3'd2);
        rom[4] = f_alu(OP_ADD);
        rom[5] = f_cp(3'd3, 3'd6);
        rom[6] = HALT;
        start(1'b0);
        exp_q.push_back(16'd8);
        run(100);
        check("t1 first_out_cycle", first_out, 12);
        check("t1 halt_addr", obs_addr, 6);
        repeat (5) step();
        check("t1 halt_frozen",
              {obs_halted, obs_in_ready, obs_out_valid, obs_addr},
              {1'b1, 1'b0, 1'b0, 8'd6});

        foreach (alu_tab[i]) begin
            tag = $sformatf("alu[%0d]", i);
            clear_rom();
            rom[0] = f_cp(3'd6, 3'd1);
            rom[1] = f_cp(3'd6, 3'd2);
            rom[2] = f_alu(alu_tab[i].op);
            rom[3] = f_cp(3'd3, 3'd6);
            rom[4] = HALT;
            start(alu_tab[i].s);
            in_q.push_back(alu_tab[i].a);
            in_q.push_back(alu_tab[i].b);
            exp_q.push_back(alu_tab[i].y);
            run(100);
        end

        foreach (cond_tab[i]) begin
            tag = $sformatf("cond[%0d]", i);
            clear_rom();
            rom[0]  = f_cp(3'd6, 3'd3);
            rom[1]  = f_imm(6'd9);
            rom[2]  = f_cnd(cond_tab[i].cc);
            rom[3]  = f_cp(3'd0, 3'd6);
            rom[4]  = HALT;
            rom[9]  = f_cp(3'd3, 3'd6);
            rom[10] = HALT;
            start(cond_tab[i].s);
            in_q.push_back(cond_tab[i].r3);
            exp_q.push_back(cond_tab[i].taken ? cond_tab[i].r3 : 16'd9);
            run(100);
            check({tag, " halt_addr"}, obs_addr,
                  cond_tab[i].taken ? 10 : 4);
        end

        tag = "in_stall";
        clear_rom();
        rom[0] = f_cp(3'd6, 3'd1);
        rom[1] = f_cp(3'd1, 3'd6);
        rom[2] = HALT;
        start(1'b0);
        in_delay = 4;
        in_q.push_back(16'h00A5);
        exp_q.push_back(16'h00A5);
        run(100);
        check("in_stall ready_cycles", in_rdy_cyc, 5);
        check("in_stall addr_moved", in_addr_bad, 0);
        check("in_stall halt_addr", obs_addr, 2);

        tag = "out_stall";
        clear_rom();
        rom[0] = f_cp(3'd6, 3'd2);
        rom[1] = f_cp(3'd2, 3'd6);
        rom[2] = HALT;
        start(1'b0);
        out_delay = 3;
        in_q.push_back(16'h003C);
        exp_q.push_back(16'h003C);
        run(100);
        check("out_stall valid_cycles", out_vld_cyc, 4);
        check("out_stall data_unstable", unstable, 0);
        check("out_stall final_valid", obs_out_valid, 0);

        tag = "copy_special";
        clear_rom();
        rom[0] = f_cp(3'd6, 3'd6);
        rom[1] = f_cp(3'd1, 3'd6);
        rom[2] = f_cp(3'd6, 3'd1);
        rom[3] = f_cp(3'd7, 3'd1);
        rom[4] = f_cp(3'd1, 3'd6);
        rom[5] = f_cp(3'd7, 3'd6);
        rom[6] = f_cp(3'd6, 3'd7);
        rom[7] = f_cp(3'd1, 3'd6);
        rom[8] = HALT;
        start(1'b0);
        in_delay = 1;
        out_delay = 1;
        in_q.push_back(16'h005A);
        in_q.push_back(16'h00A5);
        in_q.push_back(16'h0077);
        exp_q.push_back(16'h005A);
        repeat (4) exp_q.push_back(16'h0000);
        run(200);
        check("copy_special halt_addr", obs_addr, 8);

        tag = "pc_wrap";
        clear_rom();
        rom[0]  = f_cp(3'd6, 3'd6);
        rom[1]  = f_cp(3'd6, 3'd3);
        rom[2]  = f_imm(6'd5);
        rom[3]  = f_cnd(3'd5);
        rom[4]  = HALT;
        rom[5]  = f_imm(6'd15);
        rom[6]  = f_cnd(3'd4);
        rom[15] = f_cnd(3'd0);
        start(1'b1);
        in_q.push_back(16'h0011);
        in_q.push_back(16'h0022);
        in_q.push_back(16'h0033);
        in_q.push_back(16'h0000);
        exp_q.push_back(16'h0011);
        exp_q.push_back(16'h0033);
        run(200);
        check("pc_wrap halt_addr", obs_addr, 4);

        tag = "rst_stall";
        clear_rom();
        rom[0] = f_imm(6'd7);
        rom[1] = f_cp(3'd0, 3'd6);
        rom[2] = HALT;
        start(1'b0);
        for (int c = 0; c < 50 && !obs_out_valid; c++) step();
        check("rst_stall reached_out", obs_out_valid, 1);
        repeat (2) step();
        check("rst_stall held", {obs_out_valid, obs_out_data, obs_addr},
              {1'b1, 16'h0007, 8'd1});
        #2 rst_a = 1'b0;
        #1;
        check("rst_stall async_drop",
              {obs_out_valid, obs_in_ready, obs_halted,
               obs_out_data, obs_addr}, 32'h0);
        step();
        rst_a = 1'b1;

        check("ready_valid_overlap", overlap, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
